// File: rtl/phy16_rx_sync_monitor.sv
// Receive-side link monitor for a 16-bit 8b10b PHY word interface: comma-based link-sync FSM,
// error/loss statistics, and an optional frame tracker enabled by PHY16_RX_FRAME_STATS_EN.
module phy16_rx_sync_monitor #(
  parameter int unsigned g_acq_commas    = 4,
  parameter int unsigned g_loss_errors   = 4,
  parameter int unsigned g_good_to_clear = 4,
  parameter int unsigned g_cnt_width     = 16
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [15:0]            phy_rx_data_i,
  input  logic [1:0]             phy_rx_k_i,
  input  logic                   phy_rx_enc_err_i,
  input  logic                   cnt_clr_i,
  output logic                   link_up_o,
  output logic [1:0]             sync_state_o,
  output logic [g_cnt_width-1:0] err_cnt_o,
  output logic [g_cnt_width-1:0] los_cnt_o,
  output logic [g_cnt_width-1:0] frame_cnt_o,
  output logic [g_cnt_width-1:0] frame_err_cnt_o,
  output logic [15:0]            frame_len_o
);

  localparam int unsigned AcqW  = $clog2(g_acq_commas + 1);
  localparam int unsigned BadW  = $clog2(g_loss_errors + 1);
  localparam int unsigned GoodW = $clog2(g_good_to_clear + 1);

  typedef enum logic [1:0] {StLos = 2'd0, StAcq = 2'd1, StSync = 2'd2, StResync = 2'd3} state_e;

  state_e           r_state, w_state_nxt;
  logic [AcqW-1:0]  r_acq, w_acq_nxt;
  logic [BadW-1:0]  r_bad_cr, w_bad_cr_nxt;
  logic [GoodW-1:0] r_good, w_good_nxt;
  logic [g_cnt_width-1:0] r_err_cnt, r_los_cnt;
  logic w_idle, w_bad, w_link_up, w_link_up_nxt;

  function automatic logic valid_k(input logic [7:0] b);
    return (b == 8'hBC) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

  function automatic logic [g_cnt_width-1:0] sat_add(input logic [g_cnt_width-1:0] a,
                                                    input logic [1:0] inc);
    logic [g_cnt_width:0] s;
    s = {1'b0, a} + {{(g_cnt_width-1){1'b0}}, inc};
    return s[g_cnt_width] ? '1 : s[g_cnt_width-1:0];
  endfunction

  assign w_idle = (phy_rx_k_i == 2'b10) && (phy_rx_data_i[15:8] == 8'hBC) &&
                  ((phy_rx_data_i[7:0] == 8'h50) || (phy_rx_data_i[7:0] == 8'hC5)) &&
                  !phy_rx_enc_err_i;
  assign w_bad  = phy_rx_enc_err_i ||
                  (phy_rx_k_i[0] && (phy_rx_data_i[7:0] == 8'hBC)) ||
                  (phy_rx_k_i[1] && !valid_k(phy_rx_data_i[15:8])) ||
                  (phy_rx_k_i[0] && !valid_k(phy_rx_data_i[7:0]));

  assign w_link_up     = (r_state == StSync) || (r_state == StResync);
  assign w_link_up_nxt = (w_state_nxt == StSync) || (w_state_nxt == StResync);

  always_comb begin
    w_state_nxt  = r_state;
    w_acq_nxt    = r_acq;
    w_bad_cr_nxt = r_bad_cr;
    w_good_nxt   = r_good;
    unique case (r_state)
      StLos: begin
        if (w_idle) begin
          w_acq_nxt   = AcqW'(1);
          w_state_nxt = (g_acq_commas == 1) ? StSync : StAcq;
        end
      end
      StAcq: begin
        if (w_bad) begin
          w_state_nxt = StLos;
          w_acq_nxt   = '0;
        end else if (w_idle) begin
          w_acq_nxt = r_acq + AcqW'(1);
          if (32'(r_acq) + 32'd1 >= g_acq_commas) w_state_nxt = StSync;
        end
      end
      StSync: begin
        if (w_bad) begin
          w_state_nxt  = StResync;
          w_bad_cr_nxt = BadW'(1);
          w_good_nxt   = '0;
        end
      end
      StResync: begin
        if (w_bad) begin
          w_bad_cr_nxt = r_bad_cr + BadW'(1);
          w_good_nxt   = '0;
          if (32'(r_bad_cr) + 32'd1 >= g_loss_errors) w_state_nxt = StLos;
        end else if (32'(r_good) + 32'd1 >= g_good_to_clear) begin
          w_good_nxt   = '0;
          w_bad_cr_nxt = r_bad_cr - BadW'(1);
          if (r_bad_cr == BadW'(1)) w_state_nxt = StSync;
        end else begin
          w_good_nxt = r_good + GoodW'(1);
        end
      end
      default: w_state_nxt = StLos;
    endcase
    if (!enable_i) w_state_nxt = StLos;
    // Scratch counters restart from zero on every fresh acquisition.
    if (w_state_nxt == StLos) begin
      w_acq_nxt    = '0;
      w_bad_cr_nxt = '0;
      w_good_nxt   = '0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= StLos;
      r_acq     <= '0;
      r_bad_cr  <= '0;
      r_good    <= '0;
      r_err_cnt <= '0;
      r_los_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acq    <= w_acq_nxt;
      r_bad_cr <= w_bad_cr_nxt;
      r_good   <= w_good_nxt;
      if (cnt_clr_i) begin
        r_err_cnt <= '0;
        r_los_cnt <= '0;
      end else begin
        if (enable_i && w_bad && w_link_up) r_err_cnt <= sat_add(r_err_cnt, 2'd1);
        if (w_link_up && !w_link_up_nxt)    r_los_cnt <= sat_add(r_los_cnt, 2'd1);
      end
    end
  end

  assign link_up_o    = w_link_up;
  assign sync_state_o = r_state;
  assign err_cnt_o    = r_err_cnt;
  assign los_cnt_o    = r_los_cnt;

`ifdef PHY16_RX_FRAME_STATS_EN
  logic                   r_in_frame, w_in_frame_nxt;
  logic [15:0]            r_len, w_len_nxt, r_frame_len, w_frame_len_nxt;
  logic [g_cnt_width-1:0] r_frame_cnt, r_frame_err_cnt;
  logic                   w_good_inc;
  logic [1:0]             w_err_inc;

  // Bytes are walked high then low so two events in one word resolve in time order.
  always_comb begin
    logic [7:0] b;
    w_in_frame_nxt  = r_in_frame;
    w_len_nxt       = r_len;
    w_frame_len_nxt = r_frame_len;
    w_good_inc      = 1'b0;
    w_err_inc       = 2'd0;
    b               = 8'h00;
    if (w_link_up) begin
      if (w_bad) begin
        if (w_in_frame_nxt) w_err_inc = w_err_inc + 2'd1;
        w_in_frame_nxt = 1'b0;
      end else begin
        for (int i = 1; i >= 0; i--) begin
          b = phy_rx_data_i[i*8 +: 8];
          if (phy_rx_k_i[i]) begin
            if (b == 8'hFB) begin
              if (w_in_frame_nxt) w_err_inc = w_err_inc + 2'd1;
              w_in_frame_nxt = 1'b1;
              w_len_nxt      = '0;
            end else if (b == 8'hFD) begin
              if (w_in_frame_nxt) begin
                w_good_inc      = 1'b1;
                w_frame_len_nxt = w_len_nxt;
              end
              w_in_frame_nxt = 1'b0;
            end else if ((b == 8'hFE) || (b == 8'hBC)) begin
              if (w_in_frame_nxt) w_err_inc = w_err_inc + 2'd1;
              w_in_frame_nxt = 1'b0;
            end
          end else if (w_in_frame_nxt && (w_len_nxt != 16'hFFFF)) begin
            w_len_nxt = w_len_nxt + 16'd1;
          end
        end
      end
      if (w_in_frame_nxt && !w_link_up_nxt) begin
        w_err_inc      = w_err_inc + 2'd1;
        w_in_frame_nxt = 1'b0;
      end
    end else begin
      w_in_frame_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_in_frame      <= 1'b0;
      r_len           <= '0;
      r_frame_len     <= '0;
      r_frame_cnt     <= '0;
      r_frame_err_cnt <= '0;
    end else begin
      r_in_frame <= w_in_frame_nxt;
      r_len      <= w_len_nxt;
      if (cnt_clr_i) begin
        r_frame_len     <= '0;
        r_frame_cnt     <= '0;
        r_frame_err_cnt <= '0;
      end else begin
        r_frame_len     <= w_frame_len_nxt;
        r_frame_cnt     <= sat_add(r_frame_cnt, {1'b0, w_good_inc});
        r_frame_err_cnt <= sat_add(r_frame_err_cnt, w_err_inc);
      end
    end
  end

  assign frame_cnt_o     = r_frame_cnt;
  assign frame_err_cnt_o = r_frame_err_cnt;
  assign frame_len_o     = r_frame_len;
`else
  assign frame_cnt_o     = '0;
  assign frame_err_cnt_o = '0;
  assign frame_len_o     = '0;
`endif

endmodule

// File: tb/tb_phy16_rx_sync_monitor.sv
// Directed self-checking bench for phy16_rx_sync_monitor; frame checks follow
// PHY16_RX_FRAME_STATS_EN.
module tb_phy16_rx_sync_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] data;
  logic [1:0]  k;
  logic        enc_err;
  logic        cnt_clr;
  logic        link_up;
  logic [1:0]  state;
  logic [15:0] err_cnt, los_cnt, frame_cnt, frame_err_cnt, frame_len;

  int n_checks = 0;
  int n_fail   = 0;

  phy16_rx_sync_monitor dut (
    .clk_sys_i       (clk),
    .rst_n_i         (rst_n),
    .enable_i        (enable),
    .phy_rx_data_i   (data),
    .phy_rx_k_i      (k),
    .phy_rx_enc_err_i(enc_err),
    .cnt_clr_i       (cnt_clr),
    .link_up_o       (link_up),
    .sync_state_o    (state),
    .err_cnt_o       (err_cnt),
    .los_cnt_o       (los_cnt),
    .frame_cnt_o     (frame_cnt),
    .frame_err_cnt_o (frame_err_cnt),
    .frame_len_o     (frame_len)
  );

  always #5 clk = ~clk;

  // Drive one word on the falling edge; outputs are then sampled 1 ns after the rising edge.
  task automatic send(input logic [15:0] d, input logic [1:0] kk, input logic e);
    @(negedge clk);
    data    = d;
    k       = kk;
    enc_err = e;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; data = 16'h0; k = 2'b00; enc_err = 1'b0; cnt_clr = 1'b0;
    #12;
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL reset_link got %0b want 0", link_up); end
    n_checks++; if (err_cnt !== 16'd0 || los_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt got err=%0d los=%0d want 0,0", err_cnt, los_cnt); end
    n_checks++; if (frame_cnt !== 16'd0 || frame_err_cnt !== 16'd0 || frame_len !== 16'd0) begin
      n_fail++; $display("FAIL reset_frame got %0d %0d %0d want 0", frame_cnt, frame_err_cnt, frame_len); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_acquire();
    logic [1:0] exp_st [4];
    exp_st = '{2'd1, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      send(16'hBC50, 2'b10, 1'b0);
      n_checks++; if (state !== exp_st[i]) begin
        n_fail++; $display("FAIL acq_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
    end
    n_checks++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL acq_link got %0b want 1", link_up); end
  endtask

  task automatic test_resync_recover();
    logic [1:0] exp_st [4];
    exp_st = '{2'd3, 2'd3, 2'd3, 2'd2};
    send(16'h1234, 2'b00, 1'b1);
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL resync_enter got %0d want 3", state); end
    for (int i = 0; i < 4; i++) begin
      send(16'hAAAA, 2'b00, 1'b0);
      n_checks++; if (state !== exp_st[i]) begin
        n_fail++; $display("FAIL resync_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
    end
    n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL resync_err got %0d want 1", err_cnt); end
  endtask

  task automatic test_loss();
    logic [1:0] exp_st [4];
    exp_st = '{2'd3, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send(16'h50BC, 2'b01, 1'b0);
      n_checks++; if (state !== exp_st[i]) begin
        n_fail++; $display("FAIL loss_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
    end
    n_checks++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL loss_link got %0b want 0", link_up); end
    n_checks++; if (los_cnt !== 16'd1) begin n_fail++; $display("FAIL loss_los got %0d want 1", los_cnt); end
    n_checks++; if (err_cnt !== 16'd5) begin n_fail++; $display("FAIL loss_err got %0d want 5", err_cnt); end
  endtask

  task automatic test_acq_abort();
    logic [1:0] exp_st [4];
    exp_st = '{2'd1, 2'd1, 2'd1, 2'd2};
    send(16'hBC50, 2'b10, 1'b0);
    send(16'hBCC5, 2'b10, 1'b0);
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL abort_acq got %0d want 1", state); end
    send(16'h50BC, 2'b01, 1'b0);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL abort_los got %0d want 0", state); end
    for (int i = 0; i < 4; i++) begin
      send(16'hBC50, 2'b10, 1'b0);
      n_checks++; if (state !== exp_st[i]) begin
        n_fail++; $display("FAIL abort_reacq[%0d] got %0d want %0d", i, state, exp_st[i]); end
    end
    n_checks++; if (err_cnt !== 16'd5) begin n_fail++; $display("FAIL abort_err got %0d want 5", err_cnt); end
  endtask

  task automatic test_frame();
    send(16'hFB55, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) send(16'hAAAA, 2'b00, 1'b0);
    send(16'hFD50, 2'b10, 1'b0);
`ifdef PHY16_RX_FRAME_STATS_EN
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL frame_cnt got %0d want 1", frame_cnt); end
    n_checks++; if (frame_len !== 16'd7) begin n_fail++; $display("FAIL frame_len got %0d want 7", frame_len); end
    n_checks++; if (frame_err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL frame_err got %0d want 0", frame_err_cnt); end
`else
    n_checks++; if (frame_cnt !== 16'd0 || frame_len !== 16'd0 || frame_err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL frame_tied got %0d %0d %0d want 0", frame_cnt, frame_len, frame_err_cnt); end
`endif
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL frame_state got %0d want 2", state); end
  endtask

  task automatic test_enable_drop_clear();
    send(16'hFB55, 2'b10, 1'b0);
    enable = 1'b0;
    send(16'hAAAA, 2'b00, 1'b0);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL drop_state got %0d want 0", state); end
    n_checks++; if (los_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_los got %0d want 2", los_cnt); end
`ifdef PHY16_RX_FRAME_STATS_EN
    n_checks++; if (frame_err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL drop_frame_err got %0d want 1", frame_err_cnt); end
`endif
    send(16'hBC50, 2'b10, 1'b0);
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL drop_hold got %0d want 0", state); end
    cnt_clr = 1'b1;
    send(16'hBC50, 2'b10, 1'b0);
    n_checks++; if (err_cnt !== 16'd0 || los_cnt !== 16'd0) begin
      n_fail++; $display("FAIL clr_cnt got err=%0d los=%0d want 0,0", err_cnt, los_cnt); end
    n_checks++; if (frame_cnt !== 16'd0 || frame_err_cnt !== 16'd0 || frame_len !== 16'd0) begin
      n_fail++; $display("FAIL clr_frame got %0d %0d %0d want 0", frame_cnt, frame_err_cnt, frame_len); end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(16'hBC50, 2'b10, 1'b0);
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL b2b_sync got %0d want 2", state); end
    send(16'hFB55, 2'b10, 1'b0);
    send(16'hFDFB, 2'b11, 1'b0);
`ifdef PHY16_RX_FRAME_STATS_EN
    n_checks++; if (frame_cnt !== 16'd1 || frame_len !== 16'd1) begin
      n_fail++; $display("FAIL b2b_first got cnt=%0d len=%0d want 1,1", frame_cnt, frame_len); end
`endif
    send(16'hAAAA, 2'b00, 1'b0);
    send(16'hFD50, 2'b10, 1'b0);
`ifdef PHY16_RX_FRAME_STATS_EN
    n_checks++; if (frame_cnt !== 16'd2 || frame_len !== 16'd2 || frame_err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL b2b_second got cnt=%0d len=%0d err=%0d want 2,2,0",
                         frame_cnt, frame_len, frame_err_cnt); end
`endif
    n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_err got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_resync_recover();
    test_loss();
    test_acq_abort();
    test_frame();
    test_enable_drop_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
